// File: rtl/afifo_rdrain_ctrl.sv
// Read-side drain engine for the async FIFO read port: consumes a commanded
// number of words with an optional inter-read gap into a valid/ready register.
module afifo_rdrain_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic [7:0]            cmd_gap,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  rd_total
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [7:0]              gap_reg_q, gap_reg_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic                    done_q, done_d;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CNT_WIDTH-1:0]    rd_total_q;

  // The FIFO address width only matters to the surrounding read interface.
  if (ADDR_WIDTH < 1) begin : g_addr_width_unused
  end

  // State, counters and the single-entry output register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      gap_reg_q   <= 8'd0;
      gap_cnt_q   <= 8'd0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_total_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_reg_q   <= gap_reg_d;
      gap_cnt_q   <= gap_cnt_d;
      done_q      <= done_d;
      if (rinc) begin
        out_data_q  <= rdata;
        out_valid_q <= 1'b1;
        rd_total_q  <= rd_total_q + CNT_ONE;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_reg_d   = gap_reg_q;
    gap_cnt_d   = gap_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          remaining_d = cmd_count;
          gap_reg_d   = cmd_gap;
          state_d     = (cmd_count == '0) ? S_DRAIN : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rinc) begin
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = S_DRAIN;
          end else if (gap_reg_q != 8'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_reg_q;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (gap_cnt_q <= 8'd1) begin
          state_d = S_READ;
        end else begin
          state_d = S_GAP;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the register is empty after this edge, so done
        // follows the final handshake by one cycle.
        if (!out_valid_q || out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs; rinc is combinational so a word can be taken every cycle.
  always_comb begin
    rinc      = !rrst && (state_q == S_READ) && !rempty && (!out_valid_q || out_ready);
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    done      = done_q;
    rd_total  = rd_total_q;
  end

endmodule

// File: tb/tb_afifo_rdrain_ctrl.sv
// Scoreboard bench for afifo_rdrain_ctrl: a FIFO model feeds rdata/rempty,
// expected words are queued at push time and checked at each handshake.
module tb_afifo_rdrain_ctrl;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_count;
  logic [7:0]  cmd_gap;
  logic        rempty;
  logic [31:0] rdata;
  logic        rinc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [15:0] rd_total;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];
  logic [5:0]  head = 6'd0;
  logic [5:0]  tail = 6'd0;
  logic        tb_flush = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] rt, dt, bt;

  afifo_rdrain_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rrst(rrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_gap(cmd_gap), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .rd_total(rd_total)
  );

  always #5 rclk = ~rclk;

  assign rempty = (head == tail);
  assign rdata  = mem[head];

  always @(posedge rclk) begin
    if (tb_flush) head <= tail;
    else if (rinc) head <= head + 6'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: underflow guard every cycle, scoreboard pop on each handshake.
  always @(negedge rclk) begin
    if (rrst === 1'b0) begin
      check("no_underflow", {63'd0, rinc & rempty}, 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, out_data}, 64'hDEAD_0000_0000);
        end else begin
          check("out_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[tail] = w;
    tail = tail + 6'd1;
    exp_q.push_back(w);
  endtask

  task automatic issue_cmd(input logic [15:0] cnt, input logic [7:0] gap);
    cmd_valid = 1'b1;
    cmd_count = cnt;
    cmd_gap   = gap;
    #1;
    check("cmd_ready_at_issue", {63'd0, cmd_ready}, 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_count = 16'hFFFF;
    cmd_gap   = 8'hFF;
  endtask

  task automatic run_trace(input int n, output logic [31:0] r, output logic [31:0] d,
                           output logic [31:0] b);
    r = 32'd0; d = 32'd0; b = 32'd0;
    for (int i = 0; i < n; i++) begin
      #1;
      r[i] = rinc; d[i] = done; b[i] = busy;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rrst = 1'b1; cmd_valid = 1'b0; cmd_count = 16'd0; cmd_gap = 8'd0; out_ready = 1'b1;
    step(); step(); step();
    #1;
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_rinc", {63'd0, rinc}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_rd_total", {48'd0, rd_total}, 64'd0);
    rrst = 1'b0;
    step();

    // 4 words, no gap, full throughput
    push_word(32'hA000_000A); push_word(32'hB000_000B);
    push_word(32'hC000_000C); push_word(32'hD000_000D);
    issue_cmd(16'd4, 8'd0);
    run_trace(8, rt, dt, bt);
    check("t1_rinc", {32'd0, rt}, 64'h0F);
    check("t1_done", {32'd0, dt}, 64'h20);
    check("t1_busy", {32'd0, bt}, 64'h1F);
    check("t1_rd_total", {48'd0, rd_total}, 64'd4);

    // 3 words, gap of 2
    push_word(32'h1111_0001); push_word(32'h1111_0002); push_word(32'h1111_0003);
    issue_cmd(16'd3, 8'd2);
    run_trace(12, rt, dt, bt);
    check("t2_rinc", {32'd0, rt}, 64'h49);
    check("t2_done", {32'd0, dt}, 64'h100);
    check("t2_busy", {32'd0, bt}, 64'hFF);
    check("t2_rd_total", {48'd0, rd_total}, 64'd7);

    // 2 words requested from an empty FIFO, data arrives later
    issue_cmd(16'd2, 8'd0);
    run_trace(5, rt, dt, bt);
    check("t3_rinc_empty", {32'd0, rt}, 64'h0);
    check("t3_busy_empty", {32'd0, bt}, 64'h1F);
    push_word(32'h2222_0001); push_word(32'h2222_0002);
    run_trace(6, rt, dt, bt);
    check("t3_rinc", {32'd0, rt}, 64'h3);
    check("t3_busy", {32'd0, bt}, 64'h7);
    check("t3_done", {32'd0, dt}, 64'h8);
    check("t3_rd_total", {48'd0, rd_total}, 64'd9);

    // backpressure after the first capture
    push_word(32'h3333_0000); push_word(32'h3333_0001); push_word(32'h3333_0002);
    out_ready = 1'b0;
    issue_cmd(16'd3, 8'd0);
    run_trace(5, rt, dt, bt);
    check("t4_rinc_stall", {32'd0, rt}, 64'h1);
    #1;
    check("t4_out_valid", {63'd0, out_valid}, 64'd1);
    check("t4_out_data_held", {32'd0, out_data}, 64'h3333_0000);
    out_ready = 1'b1;
    run_trace(6, rt, dt, bt);
    check("t4_rinc", {32'd0, rt}, 64'h3);
    check("t4_done", {32'd0, dt}, 64'h8);
    check("t4_rd_total", {48'd0, rd_total}, 64'd12);

    // zero-length command
    issue_cmd(16'd0, 8'd0);
    run_trace(4, rt, dt, bt);
    check("t5_rinc", {32'd0, rt}, 64'h0);
    check("t5_done", {32'd0, dt}, 64'h2);
    check("t5_busy", {32'd0, bt}, 64'h1);
    check("t5_rd_total", {48'd0, rd_total}, 64'd12);

    // reset with 5 words still outstanding
    for (int i = 0; i < 8; i++) push_word(32'h4444_0000 + i);
    issue_cmd(16'd8, 8'd0);
    step(); step(); step();
    #1;
    check("t6_rinc_before_rst", {63'd0, rinc}, 64'd1);
    rrst = 1'b1;
    #1;
    check("t6_rinc_in_rst", {63'd0, rinc}, 64'd0);
    tb_flush = 1'b1;
    exp_q.delete();
    step();
    rrst = 1'b0;
    tb_flush = 1'b0;
    #1;
    check("t6_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rd_total", {48'd0, rd_total}, 64'd0);
    run_trace(3, rt, dt, bt);
    check("t6_no_done", {32'd0, dt}, 64'h0);
    push_word(32'h5555_0001);
    issue_cmd(16'd1, 8'd0);
    run_trace(4, rt, dt, bt);
    check("t6b_rinc", {32'd0, rt}, 64'h1);
    check("t6b_done", {32'd0, dt}, 64'h4);
    check("t6b_busy", {32'd0, bt}, 64'h3);
    check("t6b_rd_total", {48'd0, rd_total}, 64'd1);

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/afifo_rdrain_ctrl.md
Name: afifo_rdrain_ctrl

Overview:
- Synthesizable read-side consumer engine for the async FIFO read port. It is the active counterpart to the passive read monitor.
- Accepts a command (word count, inter-read gap) and issues rinc pulses against rempty. It captures rdata into a single-entry valid/ready output register.
- Pulses done when the commanded words have been consumed and drained downstream.
- Sits in the rclk domain, between afifo_rif read signals and a downstream checker or sink.

Parameters:
- DATA_WIDTH, 32, width of rdata/out_data.
- ADDR_WIDTH, 8, FIFO address width; informational only, kept for interface parity.
- CNT_WIDTH, 16, width of cmd_count, the remaining counter and rd_total.

Ports:
- rclk  in  1  read-domain clock.
- rrst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_count  in  CNT_WIDTH  number of words to read.
- cmd_gap  in  8  minimum idle cycles between consecutive rinc pulses.
- rempty  in  1  FIFO empty flag, synchronous to rclk.
- rdata  in  DATA_WIDTH  FIFO head word, valid whenever rempty=0 (FWFT).
- rinc  out  1  read-increment to FIFO.
- out_valid  out  1  captured word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  captured word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- rd_total  out  CNT_WIDTH  free-running count of rinc pulses.

Behaviour:
- One clock; reset is synchronous and active-high (rrst sampled on posedge rclk).
- Reset values:
  - state=IDLE, cmd_ready=1, rinc=0.
  - out_valid=0, out_data=0, busy=0, done=0, rd_total=0.
  - remaining=0, gap_cnt=0.
- rinc is combinational: rinc = !rrst & state==READ & !rempty & (!out_valid | out_ready).
  - rinc is never high while rempty=1 (no underflow).
  - rinc is never high during a reset cycle.
- Output register, on each edge:
  - if rinc: out_data<=rdata, out_valid<=1.
  - else if out_ready: out_valid<=0.
  - Simultaneous handshake and rinc: out_valid stays 1 and out_data is replaced.
- Throughput is 1 word/cycle when gap=0, rempty=0 and out_ready=1.
- States:
  - IDLE: cmd_ready=1. On cmd_valid:
    - load remaining=cmd_count and gap_reg=cmd_gap.
    - go to READ, or to DRAIN if cmd_count==0.
  - READ: on rinc, remaining--.
    - If remaining becomes 0, go to DRAIN.
    - Else if gap_reg!=0, go to GAP with gap_cnt=gap_reg.
    - Else stay in READ.
    - No rinc: stay in READ and wait (rempty or backpressure).
  - GAP: gap_cnt-- each cycle; go to READ when gap_cnt==1. Exactly gap_reg cycles with rinc=0 occur between pulses.
  - DRAIN: wait for out_valid==0, then go to IDLE with done=1 for that first IDLE cycle.
- done:
  - Registered; high exactly one cycle.
  - Coincides with cmd_ready returning to 1.
  - A new command accepted in that same cycle is legal.
- cmd_count==0:
  - accept at edge N → DRAIN.
  - edge N+1 → IDLE with done=1.
  - No rinc is issued.
- rd_total increments on every rinc, wraps modulo 2^CNT_WIDTH, and is not cleared by commands.
- cmd inputs are ignored outside IDLE.
- Reset mid-command: the next edge forces all reset values. The in-flight out_data is discarded and no done is issued.

Test Plan:
- cmd_count=4, gap=0, FIFO holds A,B,C,D, out_ready=1:
  - rinc high 4 consecutive cycles.
  - out_data A..D on consecutive cycles.
  - done one cycle after D's handshake.
  - rd_total=4.
- cmd_count=3, gap=2:
  - rinc pattern 1,0,0,1,0,0,1.
  - done pulses once.
- cmd_count=2, FIFO empty for 5 cycles then two words pushed:
  - rinc=0 while rempty=1.
  - Both words delivered in order.
  - busy=1 throughout.
- cmd_count=3, out_ready held low after the first capture:
  - exactly one rinc and out_valid=1 with word 0 stable.
  - Releasing out_ready resumes reads with no loss or duplication.
- cmd_count=0: done exactly 2 cycles after the accept edge, rinc never asserted.
- rrst asserted mid-command with remaining=5: next cycle shows state=IDLE, out_valid=0, rd_total=0, no done; a new cmd_count=1 completes normally.
